// File: rtl/fpu_layer_scheduler_pkg.sv
// Shared types for the FPU layer scheduler: phases, FSM states, layer table entries and op ids.
package fpu_layer_scheduler_pkg;

   localparam int MAX_LAYERS = 8;
   localparam int OPW        = 4;
   localparam int LW         = $clog2(MAX_LAYERS);

   typedef enum logic [1:0] {
      FWD = 2'd0,
      BWD = 2'd1,
      UPD = 2'd2
   } phase_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_NEXT,
      S_SEEK,
      S_FINISH
   } sched_state_t;

   localparam logic [OPW-1:0] OP_NOP     = 4'd0;
   localparam logic [OPW-1:0] OP_LINEAR  = 4'd1;
   localparam logic [OPW-1:0] OP_RELU    = 4'd2;
   localparam logic [OPW-1:0] OP_SOFTMAX = 4'd3;
   localparam logic [OPW-1:0] OP_MSE     = 4'd4;

   typedef struct packed {
      logic [OPW-1:0] opcode;
      logic           has_param;
   } layer_entry_t;

   typedef logic [2+OPW-1:0] op_id_t;

   function automatic op_id_t pack_op(input phase_t ph, input logic [OPW-1:0] opc);
      return {ph, opc};
   endfunction

endpackage

// File: rtl/fpu_layer_scheduler_layer_table.sv
// Layer table: one entry per model layer, single write port, asynchronous read, cleared on reset.
module layer_table
   import fpu_layer_scheduler_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           we,
   input  logic [LW-1:0]  waddr,
   input  logic [OPW-1:0] wr_opcode,
   input  logic           wr_has_param,
   input  logic [LW-1:0]  raddr,
   output logic [OPW-1:0] rd_opcode,
   output logic           rd_has_param
);

   layer_entry_t entries [MAX_LAYERS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_LAYERS; i++) begin
            entries[i] <= '0;
         end
      end else if (we) begin
         entries[waddr] <= '{opcode: wr_opcode, has_param: wr_has_param};
      end
   end

   assign rd_opcode    = entries[raddr].opcode;
   assign rd_has_param = entries[raddr].has_param;

endmodule

// File: rtl/fpu_layer_scheduler.sv
// Sequences FPUBank ops over the configured layers: forward pass, and for training a backward pass
// followed by an update pass over layers that hold parameters.
//
// state    | meaning
// IDLE     | waiting for start; layer table and count writable
// ISSUE    | op presented, fpu_go fires when FPUBank is available
// WAIT     | op in flight, waiting for fpu_done
// NEXT     | advance index / phase after an op completes
// SEEK     | update pass: scan forward for the next layer with parameters
// FINISH   | one-cycle run_done, then back to IDLE
module fpu_layer_scheduler
   import fpu_layer_scheduler_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [LW-1:0]   cfg_idx,
   input  logic [OPW-1:0]  cfg_opcode,
   input  logic            cfg_has_param,
   input  logic            cfg_num_we,
   input  logic [LW:0]     cfg_num,
   input  logic            start,
   input  logic            train,
   input  logic            fpu_avail,
   input  logic            fpu_done,
   output logic [2+OPW-1:0] fpu_op,
   output logic            fpu_go,
   output logic [LW-1:0]   layer_idx,
   output logic [1:0]      phase,
   output logic            busy,
   output logic            run_done,
   output logic            err
);

   localparam logic [LW:0] NUM_MAX = (LW+1)'(MAX_LAYERS);

   sched_state_t   state, state_n;
   phase_t         phase_q, phase_n;
   logic [LW-1:0]  idx_q, idx_n;
   logic [LW:0]    num_q;
   logic           train_q, train_n;
   logic           err_q, err_n;
   logic           cfg_open;
   logic           is_last;
   logic [OPW-1:0] rd_opcode;
   logic           rd_has_param;

   assign cfg_open = (state == S_IDLE);
   assign is_last  = ({1'b0, idx_q} == (num_q - 1'b1));

   layer_table u_layer_table (
      .clk          (clk),
      .rst          (rst),
      .we           (cfg_we && cfg_open),
      .waddr        (cfg_idx),
      .wr_opcode    (cfg_opcode),
      .wr_has_param (cfg_has_param),
      .raddr        (idx_q),
      .rd_opcode    (rd_opcode),
      .rd_has_param (rd_has_param)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         phase_q <= FWD;
         idx_q   <= '0;
         num_q   <= '0;
         train_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         phase_q <= phase_n;
         idx_q   <= idx_n;
         train_q <= train_n;
         err_q   <= err_n;
         if (cfg_num_we && cfg_open) begin
            num_q <= (cfg_num > NUM_MAX) ? NUM_MAX : cfg_num;
         end
      end
   end

   always_comb begin
      state_n = state;
      phase_n = phase_q;
      idx_n   = idx_q;
      train_n = train_q;
      err_n   = err_q;
      fpu_go  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (num_q != '0) begin
                  train_n = train;
                  idx_n   = '0;
                  phase_n = FWD;
                  state_n = S_ISSUE;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (fpu_avail) begin
               fpu_go  = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fpu_done) state_n = S_NEXT;
         end
         S_NEXT: begin
            case (phase_q)
               FWD: begin
                  if (!is_last) begin
                     idx_n   = idx_q + 1'b1;
                     state_n = S_ISSUE;
                  end else if (!train_q) begin
                     state_n = S_FINISH;
                  end else begin
                     // backward pass starts on the same (last) layer
                     phase_n = BWD;
                     state_n = S_ISSUE;
                  end
               end
               BWD: begin
                  if (idx_q != '0) begin
                     idx_n   = idx_q - 1'b1;
                     state_n = S_ISSUE;
                  end else begin
                     phase_n = UPD;
                     state_n = S_SEEK;
                  end
               end
               default: begin
                  if (is_last) begin
                     state_n = S_FINISH;
                  end else begin
                     idx_n   = idx_q + 1'b1;
                     state_n = S_SEEK;
                  end
               end
            endcase
         end
         S_SEEK: begin
            if (rd_has_param) begin
               state_n = S_ISSUE;
            end else if (is_last) begin
               state_n = S_FINISH;
            end else begin
               idx_n = idx_q + 1'b1;
            end
         end
         S_FINISH: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   assign fpu_op    = pack_op(phase_q, rd_opcode);
   assign layer_idx = idx_q;
   assign phase     = phase_q;
   assign busy      = (state != S_IDLE) && (state != S_FINISH);
   assign run_done  = (state == S_FINISH);
   assign err       = err_q;

endmodule

// File: tb/tb_fpu_layer_scheduler.sv
// Directed self-checking bench for fpu_layer_scheduler.
module tb_fpu_layer_scheduler;
   import fpu_layer_scheduler_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_we;
   logic [LW-1:0]   cfg_idx;
   logic [OPW-1:0]  cfg_opcode;
   logic            cfg_has_param;
   logic            cfg_num_we;
   logic [LW:0]     cfg_num;
   logic            start;
   logic            train;
   logic            fpu_avail;
   logic            fpu_done;
   logic [2+OPW-1:0] fpu_op;
   logic            fpu_go;
   logic [LW-1:0]   layer_idx;
   logic [1:0]      phase;
   logic            busy;
   logic            run_done;
   logic            err;

   always #5 clk = ~clk;

   fpu_layer_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_we        (cfg_we),
      .cfg_idx       (cfg_idx),
      .cfg_opcode    (cfg_opcode),
      .cfg_has_param (cfg_has_param),
      .cfg_num_we    (cfg_num_we),
      .cfg_num       (cfg_num),
      .start         (start),
      .train         (train),
      .fpu_avail     (fpu_avail),
      .fpu_done      (fpu_done),
      .fpu_op        (fpu_op),
      .fpu_go        (fpu_go),
      .layer_idx     (layer_idx),
      .phase         (phase),
      .busy          (busy),
      .run_done      (run_done),
      .err           (err)
   );

   int n_checks = 0;
   int n_err    = 0;
   int n_ops;
   int rd_count;
   int rd_cyc;
   int last_done_cyc;
   logic [LW-1:0]    log_idx   [16];
   logic [1:0]       log_phase [16];
   logic [2+OPW-1:0] log_op    [16];
   logic [OPW-1:0]   exp_opc   [MAX_LAYERS];
   logic [LW-1:0]    e2_idx    [7];
   logic [1:0]       e2_ph     [7];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_entry(input int i, input logic [OPW-1:0] opc, input logic hp);
      cfg_we = 1'b1; cfg_idx = LW'(i); cfg_opcode = opc; cfg_has_param = hp;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic cfg_count(input int n);
      cfg_num_we = 1'b1; cfg_num = (LW+1)'(n);
      @(negedge clk);
      cfg_num_we = 1'b0;
   endtask

   task automatic start_run(input logic t);
      train = t; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // FPUBank stand-in: logs each go and answers with fpu_done three cycles later.
   task automatic run_ops(input int budget);
      int cnt;
      cnt = 0; n_ops = 0; rd_count = 0; rd_cyc = -1; last_done_cyc = -1;
      for (int c = 0; c < budget; c++) begin
         fpu_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               fpu_done = 1'b1;
               last_done_cyc = c;
            end
         end
         if (fpu_go) begin
            if (n_ops < 16) begin
               log_idx[n_ops] = layer_idx; log_phase[n_ops] = phase; log_op[n_ops] = fpu_op;
            end
            n_ops++;
            cnt = 3;
         end
         if (run_done) begin
            rd_count++;
            rd_cyc = c;
            break;
         end
         @(negedge clk);
      end
      fpu_done = 1'b0;
   endtask

   initial begin
      int cnt;
      logic found;
      rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_opcode = '0; cfg_has_param = 1'b0;
      cfg_num_we = 1'b0; cfg_num = '0; start = 1'b0; train = 1'b0; fpu_avail = 1'b1; fpu_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_fpu_op", fpu_op, 0);
      chk("rst_fpu_go", fpu_go, 0);
      chk("rst_layer_idx", layer_idx, 0);
      chk("rst_phase", phase, 0);
      chk("rst_busy", busy, 0);
      chk("rst_run_done", run_done, 0);
      chk("rst_err", err, 0);

      exp_opc[0] = OP_LINEAR; exp_opc[1] = OP_RELU; exp_opc[2] = OP_MSE;
      exp_opc[3] = OP_RELU; exp_opc[4] = OP_LINEAR; exp_opc[5] = OP_RELU;
      exp_opc[6] = OP_LINEAR; exp_opc[7] = OP_MSE;
      cfg_entry(0, OP_LINEAR, 1'b1);
      cfg_entry(1, OP_RELU, 1'b0);
      cfg_entry(2, OP_MSE, 1'b0);
      cfg_count(3);

      // inference N=3
      start_run(1'b0);
      chk("t1_first_go", fpu_go, 1);
      chk("t1_busy", busy, 1);
      run_ops(200);
      chk("t1_run_done_seen", rd_count, 1);
      chk("t1_n_ops", n_ops, 3);
      for (int i = 0; i < 3; i++) begin
         chk("t1_idx", log_idx[i], i);
         chk("t1_phase", log_phase[i], FWD);
         chk("t1_op", log_op[i], {FWD, exp_opc[i]});
      end
      chk("t1_done_latency", rd_cyc - last_done_cyc, 2);
      @(negedge clk);
      chk("t1_run_done_pulse", run_done, 0);
      chk("t1_busy_after", busy, 0);
      chk("t1_final_idx", layer_idx, 2);

      // training N=3, has_param={1,0,0}
      e2_idx = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0};
      e2_ph  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
      start_run(1'b1);
      run_ops(300);
      chk("t2_run_done_seen", rd_count, 1);
      chk("t2_n_ops", n_ops, 7);
      for (int i = 0; i < 7; i++) begin
         chk("t2_idx", log_idx[i], e2_idx[i]);
         chk("t2_phase", log_phase[i], e2_ph[i]);
         chk("t2_op", log_op[i], {e2_ph[i], exp_opc[e2_idx[i]]});
      end
      @(negedge clk);
      chk("t2_run_done_pulse", run_done, 0);
      chk("t2_busy_after", busy, 0);
      chk("t2_final_idx", layer_idx, 2);
      chk("t2_final_phase", phase, UPD);

      // avail low in ISSUE, stray done, config writes while busy
      fpu_avail = 1'b0;
      start_run(1'b0);
      chk("t3_busy", busy, 1);
      chk("t3_no_go", fpu_go, 0);
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            cfg_we = 1'b1; cfg_idx = '0; cfg_opcode = OP_SOFTMAX; cfg_has_param = 1'b0;
         end
         if (c == 4) begin
            cfg_num_we = 1'b1; cfg_num = 4'd1;
         end
         if (c == 6) fpu_done = 1'b1;
         @(negedge clk);
         cfg_we = 1'b0; cfg_num_we = 1'b0; fpu_done = 1'b0;
         chk("t3_hold_no_go", fpu_go, 0);
         chk("t3_op_stable", fpu_op, {FWD, OP_LINEAR});
      end
      chk("t3_idx_hold", layer_idx, 0);
      chk("t3_busy_hold", busy, 1);
      fpu_avail = 1'b1;
      #1;
      chk("t3_go_on_avail", fpu_go, 1);
      run_ops(200);
      chk("t3_run_done_seen", rd_count, 1);
      chk("t3_n_ops", n_ops, 3);
      chk("t3_op0", log_op[0], {FWD, OP_LINEAR});
      chk("t3_idx2", log_idx[2], 2);
      @(negedge clk);

      // N saturates to 8, inference reaches layer 7 without wrapping
      for (int i = 3; i < MAX_LAYERS; i++) cfg_entry(i, exp_opc[i], 1'b0);
      cfg_count(9);
      start_run(1'b0);
      run_ops(400);
      chk("t5_run_done_seen", rd_count, 1);
      chk("t5_n_ops", n_ops, 8);
      for (int i = 0; i < 8; i++) begin
         chk("t5_idx", log_idx[i], i);
         chk("t5_op", log_op[i], {FWD, exp_opc[i]});
      end
      @(negedge clk);
      chk("t5_final_idx", layer_idx, 7);
      chk("t5_busy_after", busy, 0);

      // reset during WAIT of backward layer 1
      cfg_count(3);
      train = 1'b1; start = 1'b1;
      cnt = 0; found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         start = 1'b0; fpu_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) fpu_done = 1'b1;
         end
         if (fpu_go) begin
            if (phase == BWD && layer_idx == 1) found = 1'b1;
            else cnt = 3;
         end
      end
      chk("t6_reach_bwd1", found, 1);
      @(negedge clk);
      chk("t6_in_wait_busy", busy, 1);
      chk("t6_in_wait_no_go", fpu_go, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_fpu_op", fpu_op, 0);
      chk("t6_fpu_go", fpu_go, 0);
      chk("t6_layer_idx", layer_idx, 0);
      chk("t6_phase", phase, 0);
      chk("t6_busy", busy, 0);
      chk("t6_run_done", run_done, 0);
      fpu_done = 1'b1;
      @(negedge clk);
      fpu_done = 1'b0;
      chk("t6_late_done_busy", busy, 0);
      chk("t6_late_done_go", fpu_go, 0);
      chk("t6_late_done_rd", run_done, 0);

      // start with N==0 (cleared by reset)
      start_run(1'b0);
      chk("t4_err_set", err, 1);
      chk("t4_busy", busy, 0);
      chk("t4_no_go", fpu_go, 0);
      repeat (3) @(negedge clk);
      chk("t4_err_sticky", err, 1);
      chk("t4_busy_idle", busy, 0);
      chk("t4_table_cleared", fpu_op, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_err_cleared", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fpu_layer_scheduler.md
Name: fpu_layer_scheduler

Overview:
- Sequences FPUBank operations across the configured model layers, one operation at a time.
- Inference: forward pass over layers 0..N-1.
- Training: forward pass, then backward pass N-1..0, then a parameter-update pass over the layers that hold weights.
- Sits between model_manager (configuration, start, layer index used for mem_handle selection) and FPUBank (op/avail/done handshake).

Parameters:
MAX_LAYERS, 8, layer table depth
OPW, 4, layer opcode width (layer_opcode encoding)
LW, $clog2(MAX_LAYERS), layer index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_we  in  1  write one layer table entry
cfg_idx  in  LW  entry index
cfg_opcode  in  OPW  layer opcode
cfg_has_param  in  1  layer has weights/bias (included in update pass)
cfg_num_we  in  1  write layer count
cfg_num  in  LW+1  layer count N
start  in  1  begin run (sampled only in IDLE)
train  in  1  sampled with start; 1 = forward+backward+update
fpu_avail  in  1  FPUBank ready to accept op
fpu_done  in  1  FPUBank op complete, 1-cycle pulse
fpu_op  out  2+OPW  {phase, opcode} of current op
fpu_go  out  1  op issue strobe
layer_idx  out  LW  layer being processed
phase  out  2  FWD=0, BWD=1, UPD=2
busy  out  1  run in progress
run_done  out  1  1-cycle pulse at run end
err  out  1  sticky: start issued with N==0

Behaviour:
- Reset (sync, rst=1 at posedge) clears every entry (opcode=0, has_param=0) and sets N=0, state=IDLE. Output values on the next edge: fpu_op=0, fpu_go=0, layer_idx=0, phase=FWD, busy=0, run_done=0, err=0.
- Reset mid-run abandons the run immediately. An fpu_done arriving after reset is ignored.
- Config writes take effect only in IDLE. When busy, both cfg_we and cfg_num_we are ignored. cfg_num > MAX_LAYERS saturates to MAX_LAYERS.
- States: IDLE, ISSUE, WAIT, NEXT, SEEK, FINISH.
- IDLE:
  - start && N!=0: latch train, set idx=0, phase=FWD, go to ISSUE, busy=1.
  - start && N==0: set err=1, stay in IDLE.
  - err clears only on reset.
- ISSUE:
  - fpu_op = {phase, table[idx].opcode}.
  - fpu_go = (state==ISSUE) && fpu_avail, combinational.
  - When fpu_go is asserted, go to WAIT. Otherwise hold in ISSUE.
- WAIT: fpu_op is held stable. fpu_done moves to NEXT. fpu_done seen in any other state is ignored.
- NEXT:
  - FWD: idx<N-1 → idx+1, ISSUE. idx==N-1 with train=0 → FINISH. idx==N-1 with train=1 → phase=BWD, idx=N-1, ISSUE.
  - BWD: idx>0 → idx-1, ISSUE. idx==0 → phase=UPD, idx=0, SEEK.
  - UPD: idx==N-1 → FINISH. Otherwise idx+1, SEEK.
- SEEK (UPD only, one layer checked per cycle):
  - has_param[idx] → ISSUE.
  - Else idx==N-1 → FINISH.
  - Else idx+1, stay in SEEK.
- FINISH: run_done=1 for one cycle, busy=0 on that cycle, go to IDLE. phase and layer_idx keep their final values.
- A start arriving in FINISH or when busy is ignored.
- Latency:
  - start sampled at edge t → ISSUE from t+1. If avail is high, fpu_go is asserted in cycle t+1.
  - fpu_done at edge t → next fpu_go no earlier than t+2 (NEXT is one cycle).
- Op count: inference issues N ops. Training issues 2N + P ops, where P = number of layers with has_param among 0..N-1.
- layer_idx and phase are registered and valid for the whole ISSUE/WAIT window.

Decomposition:
- Shared package (extend mmdefine):
  - phase_t enum {FWD, BWD, UPD}
  - sched_state_t enum
  - layer_entry_t struct {opcode, has_param}
  - op_id packing {phase_t, layer_opcode}
- Sub-module: layer_table (MAX_LAYERS×(OPW+1) register file, 1 write port, 1 async read port, sync clear on rst).
- FSM and index counter stay in fpu_layer_scheduler.

Test Plan:
- N=3, opcodes {LINEAR, RELU, MSE}, train=0, avail tied 1, done 3 cycles after each go → exactly 3 fpu_go, layer_idx 0,1,2, phase=FWD, run_done one cycle after third done, busy low after.
- Same table with has_param={1,0,0} and train=1 → fpu_go sequence FWD 0,1,2 / BWD 2,1,0 / UPD 0 (7 ops). SEEK skips layers 1,2. run_done pulses once.
- avail held 0 for 10 cycles in ISSUE → no fpu_go. fpu_op stable. Go is asserted the same cycle avail rises. Stray fpu_done during ISSUE is ignored.
- start with N=0 → err=1, busy stays 0, no fpu_go. err persists until rst.
- rst asserted in WAIT of BWD layer 1 → next edge: state IDLE, all outputs 0, N=0. A fpu_done pulse after reset produces no transition.
- cfg_we while busy (idx 0 → SOFTMAX) → table unchanged. Next run issues original opcode. N=MAX_LAYERS=8 inference → idx reaches 7, no wrap.
